// File: rtl/axi_pkg.sv
// Shared AXI types for the arbiter: bus widths, response codes, master index and FSM state.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic mst_idx_t;

    // Beat counter sized from arlen so a 256-beat burst never wraps.
    typedef logic [AXI_LEN_W-1:0] beat_cnt_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } arb_state_t;

endpackage

// File: rtl/axi_intf.sv
// AXI4 subset bundle (AW/W/B/AR/R) used between masters, arbiter and the shared port.
interface axi_intf;
    import axi_pkg::*;

    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_LEN_W-1:0]  awlen;
    logic                  awvalid;
    logic                  awready;

    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_LEN_W-1:0]  arlen;
    logic                  arvalid;
    logic                  arready;

    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arlen, arvalid, input arready,
        input  rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arlen, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/axi_arbiter.sv
// Two-master AXI arbiter, one locked transaction at a time, round-robin on contention.
// Grant costs one cycle; the waiting master sees ready=0 until the next IDLE; beats pass through with no buffering.
module axi_arbiter
    import axi_pkg::*;
#(
    parameter mst_idx_t RESET_PRIO = 1'b0
) (
    input  logic    clk,
    input  logic    rst,
    axi_intf.slave  axi_m0,
    axi_intf.slave  axi_m1,
    axi_intf.master axi_s,
    output logic    busy,
    output logic    owner
);

    arb_state_t state_q, state_d;
    beat_cnt_t  cnt_q, cnt_d;
    mst_idx_t   owner_q, owner_d;
    mst_idx_t   last_q, last_d;
    mst_idx_t   grant;
    logic       rd_win;
    logic       req0, req1;

    // Request fields of the current owner.
    logic [AXI_ADDR_W-1:0] sel_araddr, sel_awaddr;
    logic [AXI_LEN_W-1:0]  sel_arlen, sel_awlen;
    logic [AXI_DATA_W-1:0] sel_wdata;
    logic [AXI_STRB_W-1:0] sel_wstrb;
    logic                  sel_arvalid, sel_awvalid, sel_wvalid, sel_wlast;
    logic                  sel_rready, sel_bready;

    // Response fields before being steered to the owner.
    logic                  up_awready, up_wready, up_arready;
    logic                  up_bvalid, up_rvalid, up_rlast;
    logic [1:0]            up_bresp, up_rresp;
    logic [AXI_DATA_W-1:0] up_rdata;

    assign req0 = axi_m0.arvalid | axi_m0.awvalid;
    assign req1 = axi_m1.arvalid | axi_m1.awvalid;

    assign sel_araddr  = owner_q ? axi_m1.araddr  : axi_m0.araddr;
    assign sel_arlen   = owner_q ? axi_m1.arlen   : axi_m0.arlen;
    assign sel_arvalid = owner_q ? axi_m1.arvalid : axi_m0.arvalid;
    assign sel_rready  = owner_q ? axi_m1.rready  : axi_m0.rready;
    assign sel_awaddr  = owner_q ? axi_m1.awaddr  : axi_m0.awaddr;
    assign sel_awlen   = owner_q ? axi_m1.awlen   : axi_m0.awlen;
    assign sel_awvalid = owner_q ? axi_m1.awvalid : axi_m0.awvalid;
    assign sel_wdata   = owner_q ? axi_m1.wdata   : axi_m0.wdata;
    assign sel_wstrb   = owner_q ? axi_m1.wstrb   : axi_m0.wstrb;
    assign sel_wlast   = owner_q ? axi_m1.wlast   : axi_m0.wlast;
    assign sel_wvalid  = owner_q ? axi_m1.wvalid  : axi_m0.wvalid;
    assign sel_bready  = owner_q ? axi_m1.bready  : axi_m0.bready;

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= RESET_PRIO;
            last_q  <= ~RESET_PRIO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant   = owner_q;
        rd_win  = 1'b0;

        axi_s.awaddr  = '0;
        axi_s.awlen   = '0;
        axi_s.awvalid = 1'b0;
        axi_s.wdata   = '0;
        axi_s.wstrb   = '0;
        axi_s.wlast   = 1'b0;
        axi_s.wvalid  = 1'b0;
        axi_s.bready  = 1'b0;
        axi_s.araddr  = '0;
        axi_s.arlen   = '0;
        axi_s.arvalid = 1'b0;
        axi_s.rready  = 1'b0;

        up_awready = 1'b0;
        up_wready  = 1'b0;
        up_arready = 1'b0;
        up_bvalid  = 1'b0;
        up_bresp   = '0;
        up_rvalid  = 1'b0;
        up_rdata   = '0;
        up_rresp   = '0;
        up_rlast   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to whoever did not win last time.
                    grant   = (req0 && req1) ? ~last_q : req1;
                    rd_win  = grant ? axi_m1.arvalid : axi_m0.arvalid;
                    owner_d = grant;
                    last_d  = grant;
                    state_d = rd_win ? RD_ADDR : WR_ADDR;
                end
            end
            RD_ADDR: begin
                axi_s.araddr  = sel_araddr;
                axi_s.arlen   = sel_arlen;
                axi_s.arvalid = sel_arvalid;
                up_arready    = axi_s.arready;
                if (sel_arvalid && axi_s.arready) begin
                    cnt_d   = sel_arlen;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                axi_s.rready = sel_rready;
                up_rvalid    = axi_s.rvalid;
                up_rdata     = axi_s.rdata;
                up_rresp     = axi_s.rresp;
                up_rlast     = axi_s.rlast;
                // Completion is counted, not taken from rlast or rresp.
                if (axi_s.rvalid && sel_rready) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                axi_s.awaddr  = sel_awaddr;
                axi_s.awlen   = sel_awlen;
                axi_s.awvalid = sel_awvalid;
                up_awready    = axi_s.awready;
                if (sel_awvalid && axi_s.awready) begin
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                axi_s.wdata  = sel_wdata;
                axi_s.wstrb  = sel_wstrb;
                axi_s.wlast  = sel_wlast;
                axi_s.wvalid = sel_wvalid;
                up_wready    = axi_s.wready;
                if (sel_wvalid && axi_s.wready && sel_wlast) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                axi_s.bready = sel_bready;
                up_bvalid    = axi_s.bvalid;
                up_bresp     = axi_s.bresp;
                if (axi_s.bvalid && sel_bready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        axi_m0.awready = up_awready & ~owner_q;
        axi_m0.wready  = up_wready  & ~owner_q;
        axi_m0.arready = up_arready & ~owner_q;
        axi_m0.bvalid  = up_bvalid  & ~owner_q;
        axi_m0.rvalid  = up_rvalid  & ~owner_q;
        axi_m0.rlast   = up_rlast   & ~owner_q;
        axi_m0.bresp   = owner_q ? 2'b00 : up_bresp;
        axi_m0.rresp   = owner_q ? 2'b00 : up_rresp;
        axi_m0.rdata   = owner_q ? '0    : up_rdata;

        axi_m1.awready = up_awready & owner_q;
        axi_m1.wready  = up_wready  & owner_q;
        axi_m1.arready = up_arready & owner_q;
        axi_m1.bvalid  = up_bvalid  & owner_q;
        axi_m1.rvalid  = up_rvalid  & owner_q;
        axi_m1.rlast   = up_rlast   & owner_q;
        axi_m1.bresp   = owner_q ? up_bresp : 2'b00;
        axi_m1.rresp   = owner_q ? up_rresp : 2'b00;
        axi_m1.rdata   = owner_q ? up_rdata : '0;
    end

endmodule
